lsu_splicer: RTL and testbench
==============================

// Module: lsu_splicer
// PURPOSE
//  Parametrised load/store unit between the datapath and a data memory port.
//  Generalises the fixed load/store splice selects to any XLEN and adds a registered valid/ready memory handshake.
//  Provides byte-enable generation, sign/zero extension and optional split of misaligned accesses.
//  Sits after ALU address generation; the response feeds the register-file write-back mux.
// PARAMETERS
//  XLEN    64  data width in bits; 32 or 64; mem bus is XLEN wide, NB = XLEN/8 lanes
//  ADDR_W  64  byte-address width
// PORTS
//  clk           in   1       clock, rising edge
//  reset_n       in   1       synchronous reset, active low
//  req_valid     in   1       access request
//  req_ready     out  1       high only in IDLE
//  req_we        in   1       1=store, 0=load
//  req_size      in   2       0=B 1=H 2=W 3=D (D illegal when XLEN=32)
//  req_unsigned  in   1       load zero-extends when 1
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   XLEN    store data, right-aligned
//  rsp_valid     out  1       one-cycle pulse, access done
//  rsp_rdata     out  XLEN    extended load data; 0 for stores and errors
//  rsp_err       out  1       valid with rsp_valid: illegal size or unsupported misalignment
//  mem_valid     out  1       memory beat request
//  mem_ready     in   1       beat accepted
//  mem_we        out  1       beat is a write
//  mem_addr      out  ADDR_W  NB-aligned beat address
//  mem_wdata     out  XLEN    lane-shifted store data
//  mem_be        out  NB      byte enables
//  mem_rvalid    in   1       read data valid, at least 1 cycle after accept
//  mem_rdata     in   XLEN    read data
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 except req_ready=1. Reset mid-access aborts it; mem_valid drops next edge; stale mem_rvalid ignored.
//  - States: IDLE -> BEAT0 -> [WAIT0] -> [BEAT1 -> WAIT1] -> RESP -> IDLE.
//  - Accept when req_valid & req_ready; request latched; mem_valid asserted the next cycle.
//  - mem_* held stable while mem_valid & !mem_ready.
//  - Store beats complete on mem_ready. Load beats complete on mem_rvalid in WAITn.
//  - RESP: rsp_valid high exactly 1 cycle; req_ready returns next cycle.
//  - Minimum load latency: accept T, mem_valid T+1 (ready), rvalid T+2, rsp_valid T+3.
//  - Minimum store latency: rsp_valid T+2.
//  - Error path: illegal size goes IDLE -> RESP with rsp_err=1 and no mem beat. Misaligned access without split support also errors (see CONFIGURATION).
//  - Address split: off = addr[log2(NB)-1:0], n = 1<<size bytes, mem_addr = addr & ~(NB-1).
//  - Store lanes: mem_be = ((1<<n)-1) << off, truncated to NB. mem_wdata = wdata << 8*off.
//  - Load: bytes = rdata >> 8*off, masked to n bytes, then sign-extended from bit 8n-1 unless req_unsigned.
//  - Misalign: aligned iff addr mod n == 0.
//  - Crossing: off+n > NB. Beat0 carries k = NB-off bytes.
//  - Beat1: addr+NB (wraps mod 2^ADDR_W), be = (1<<(n-k))-1, wdata >> 8*k.
//  - Misaligned accesses that do not cross are a single beat.
//  - Load split: low k bytes from beat0, high n-k bytes from beat1, then extend.
// CONFIGURATION
//  LSU_MISALIGNED_SPLIT_EN defined: crossing accesses split into two beats as above; rsp_err only for illegal size.
//  Not defined: any misaligned access (addr mod n != 0) errors via IDLE -> RESP with no mem beat. BEAT1/WAIT1 are not built.
// TESTING
//  Reset: reset_n=0 for 2 cycles while in WAIT0 -> mem_valid=0, req_ready=1, no rsp_valid; late mem_rvalid ignored.
//  LB: XLEN=64, LB addr 0x1003, rdata 0x0000_0000_8000_0000 -> mem_addr 0x1000; rsp_rdata 0xFFFF_FFFF_FFFF_FF80 (LBU -> 0x80).
//  SH: addr 0x2006, wdata 0xABCD -> one beat, be=0xC0, wdata=0xABCD<<48, rsp_err=0.
//  Split LW (SPLIT_EN): addr 0x0FFE, beat0 rdata[63:48]=0x5678, beat1 rdata[15:0]=0x1234 -> beats 0x0FF8 then 0x1000; rsp_rdata 0x0000_0000_1234_5678.
//  Misaligned SW (no SPLIT_EN): addr 0x3001 -> no mem_valid; rsp_valid 1 cycle after accept, rsp_err=1.
//  Backpressure: mem_ready low 5 cycles -> mem_addr/be/wdata stable; rsp_valid follows handshake +1 cycle (store).
//  Illegal size: XLEN=32, size=3 -> rsp_err=1, no mem beat.

Source files
------------

// File: rtl/lsu_splicer_if.sv
// Load/store request, response and memory-port bundle for lsu_splicer.
// The slave modport is the LSU's view; master is the datapath/memory side.
interface lsu_splicer_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [NB-1:0]     mem_be;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_be
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/lsu_splicer.sv
// Load/store unit: byte-lane splicing, sign/zero extension, valid/ready memory beats.
// Define LSU_MISALIGNED_SPLIT_EN to split lane-crossing accesses into two beats.
module lsu_splicer #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  lsu_splicer_if.slave bus
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {
    IDLE, BEAT0, WAIT0,
`ifdef LSU_MISALIGNED_SPLIT_EN
    BEAT1, WAIT1,
`endif
    RESP
  } state_t;

  state_t            state, state_d;
  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q, base;
  logic [XLEN-1:0]   wdata_q, acc_q, ext;
  logic [2*NB-1:0]   be_full;
  logic [2*XLEN-1:0] w_full;
  logic              illegal_r, bad_r, split_q, in_b1, beat, sgn;
  int                n_r, n_q, off_q;

  assign n_r       = 1 << bus.req_size;
  assign n_q       = 1 << size_q;
  assign off_q     = int'(addr_q[OFF_W-1:0]);
  assign illegal_r = (XLEN == 32) && (bus.req_size == 2'd3);

`ifdef LSU_MISALIGNED_SPLIT_EN
  int k_q;
  assign k_q     = NB - off_q;
  assign bad_r   = illegal_r;
  assign split_q = (off_q + n_q) > NB;
  assign in_b1   = (state == BEAT1);
`else
  logic misal_r;
  assign misal_r = (int'(bus.req_addr[OFF_W-1:0]) & (n_r - 1)) != 0;
  assign bad_r   = illegal_r | misal_r;
  assign split_q = 1'b0;
  assign in_b1   = 1'b0;
`endif

  // Upper halves of the double-width shifts are exactly the second-beat lanes.
  assign be_full = (2*NB)'((1 << n_q) - 1) << off_q;
  assign w_full  = {{XLEN{1'b0}}, wdata_q} << (8 * off_q);
  assign base    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign beat    = (state == BEAT0) | in_b1;

  assign bus.req_ready = (state == IDLE);
  assign bus.mem_valid = beat;
  assign bus.mem_we    = beat & we_q;
  assign bus.mem_addr  = !beat ? '0 : (in_b1 ? base + ADDR_W'(NB) : base);
  assign bus.mem_be    = !beat ? '0 : (in_b1 ? be_full[2*NB-1:NB] : be_full[NB-1:0]);
  assign bus.mem_wdata = !(beat & we_q) ? '0
                       : (in_b1 ? w_full[2*XLEN-1:XLEN] : w_full[XLEN-1:0]);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = (state == RESP) & err_q;
  assign bus.rsp_rdata = ((state == RESP) & !we_q & !err_q) ? ext : '0;

  // acc_q holds the loaded bytes right-aligned; bytes above n are don't-care.
  always_comb begin
    sgn = 1'b0;
    ext = '0;
    for (int i = 0; i < NB; i++)
      if (i == n_q - 1) sgn = acc_q[8*i+7] & ~uns_q;
    for (int i = 0; i < NB; i++)
      ext[8*i +: 8] = (i < n_q) ? acc_q[8*i +: 8] : {8{sgn}};
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (bus.req_valid) state_d = bad_r ? RESP : BEAT0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      BEAT0: if (bus.mem_ready) state_d = !we_q ? WAIT0 : (split_q ? BEAT1 : RESP);
      WAIT0: if (bus.mem_rvalid) state_d = split_q ? BEAT1 : RESP;
      BEAT1: if (bus.mem_ready) state_d = we_q ? RESP : WAIT1;
      WAIT1: if (bus.mem_rvalid) state_d = RESP;
`else
      BEAT0: if (bus.mem_ready) state_d = (we_q | split_q) ? RESP : WAIT0;
      WAIT0: if (bus.mem_rvalid) state_d = RESP;
`endif
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      acc_q   <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && bus.req_valid) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= bad_r;
        acc_q   <= '0;
      end
      if (state == WAIT0 && bus.mem_rvalid)
        acc_q <= bus.mem_rdata >> (8 * off_q);
`ifdef LSU_MISALIGNED_SPLIT_EN
      if (state == WAIT1 && bus.mem_rvalid)
        acc_q <= acc_q | (bus.mem_rdata << (8 * k_q));
`endif
    end
  end
endmodule

// File: tb/tb_lsu_splicer.sv
// Directed bench for lsu_splicer: vector table on a 64-bit instance plus
// reset-abort and illegal-size sequences (32-bit instance).
module tb_lsu_splicer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lsu_splicer_if #(.XLEN(64), .ADDR_W(64)) bus ();
  lsu_splicer_if #(.XLEN(32), .ADDR_W(32)) bus32 ();

  lsu_splicer #(.XLEN(64), .ADDR_W(64)) dut   (.clk(clk), .reset_n(reset_n), .bus(bus));
  lsu_splicer #(.XLEN(32), .ADDR_W(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32));

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr, wdata;
    int          nb, stall;
    logic [63:0] ma0;
    logic [7:0]  be0;
    logic [63:0] wd0, rd0, ma1;
    logic [7:0]  be1;
    logic [63:0] wd1, rd1, exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];
  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int beat, cyc, stl, lat;
    bit pend, done;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = v.we; bus.req_size = v.size;
    bus.req_unsigned = v.uns; bus.req_addr = v.addr; bus.req_wdata = v.wdata;
    chk({v.name, " req_ready"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    beat = 0; cyc = 0; stl = v.stall; pend = 0; done = 0;
    lat = v.exp_err ? 1 : (v.we ? 1 + v.nb + v.stall : 1 + 2*v.nb + v.stall);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
      if (bus.rsp_valid) begin
        chk({v.name, " latency"}, 64'(cyc), 64'(lat));
        chk({v.name, " beats"}, 64'(beat), 64'(v.nb));
        chk({v.name, " rsp_err"}, 64'(bus.rsp_err), 64'(v.exp_err));
        chk({v.name, " rsp_rdata"}, bus.rsp_rdata, v.exp_rd);
        done = 1;
      end else if (bus.mem_valid) begin
        if (beat >= v.nb) chk({v.name, " extra beat"}, 64'(beat + 1), 64'(v.nb));
        chk({v.name, " mem_we"}, 64'(bus.mem_we), 64'(v.we));
        chk({v.name, " mem_addr"}, bus.mem_addr, beat == 0 ? v.ma0 : v.ma1);
        chk({v.name, " mem_be"}, 64'(bus.mem_be), 64'(beat == 0 ? v.be0 : v.be1));
        chk({v.name, " mem_wdata"}, bus.mem_wdata, beat == 0 ? v.wd0 : v.wd1);
        if (stl > 0) stl--;
        else begin
          bus.mem_ready = 1'b1;
          pend = !v.we;
          beat++;
        end
      end else if (pend) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = (beat == 1) ? v.rd0 : v.rd1;
        pend = 0;
      end
    end
    if (!done) chk({v.name, " timeout"}, 64'(cyc), 64'(lat));
    @(negedge clk);
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
    chk({v.name, " rsp pulse"}, 64'(bus.rsp_valid), 64'd0);
    chk({v.name, " ready back"}, 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    bus32.req_valid = 0; bus32.req_we = 0; bus32.req_size = 0; bus32.req_unsigned = 0;
    bus32.req_addr = 0; bus32.req_wdata = 0; bus32.mem_ready = 0; bus32.mem_rvalid = 0; bus32.mem_rdata = 0;

    //         name   we size uns addr          wdata                  nb st ma0           be0    wd0                    rd0                    ma1           be1    wd1           rd1                    exp_rd                 err
    tbl.push_back('{"lb",  0, 0, 0, 64'h1003, 64'h0,                 1, 0, 64'h1000, 8'h08, 64'h0,                 64'h0000_0000_8000_0000, 64'h0, 8'h00, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0});
    tbl.push_back('{"lbu", 0, 0, 1, 64'h1003, 64'h0,                 1, 0, 64'h1000, 8'h08, 64'h0,                 64'h1122_3344_8055_6677, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0000_0000_0000_0080, 0});
    tbl.push_back('{"sh",  1, 1, 0, 64'h2006, 64'hABCD,              1, 0, 64'h2000, 8'hC0, 64'hABCD_0000_0000_0000, 64'h0,                 64'h0, 8'h00, 64'h0, 64'h0, 64'h0,                 0});
    tbl.push_back('{"lw",  0, 2, 0, 64'h1004, 64'h0,                 1, 0, 64'h1000, 8'hF0, 64'h0,                 64'h8765_4321_0000_0000, 64'h0, 8'h00, 64'h0, 64'h0, 64'hFFFF_FFFF_8765_4321, 0});
    tbl.push_back('{"lwu", 0, 2, 1, 64'h1004, 64'h0,                 1, 0, 64'h1000, 8'hF0, 64'h0,                 64'h8765_4321_0000_0000, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0000_0000_8765_4321, 0});
    tbl.push_back('{"lh",  0, 1, 0, 64'h100A, 64'h0,                 1, 0, 64'h1008, 8'h0C, 64'h0,                 64'h0000_0000_7FFE_0000, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0000_0000_0000_7FFE, 0});
    tbl.push_back('{"ld",  0, 3, 0, 64'h2000, 64'h0,                 1, 0, 64'h2000, 8'hFF, 64'h0,                 64'h0123_4567_89AB_CDEF, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 0});
    tbl.push_back('{"sd_bp", 1, 3, 0, 64'h2008, 64'hDEAD_BEEF_CAFE_F00D, 1, 5, 64'h2008, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'h0,           64'h0, 8'h00, 64'h0, 64'h0, 64'h0,                 0});
    tbl.push_back('{"sb",  1, 0, 0, 64'h3007, 64'h5A,                1, 0, 64'h3000, 8'h80, 64'h5A00_0000_0000_0000, 64'h0,                 64'h0, 8'h00, 64'h0, 64'h0, 64'h0,                 0});
    tbl.push_back('{"lb_bp", 0, 0, 0, 64'h1000, 64'h0,               1, 2, 64'h1000, 8'h01, 64'h0,                 64'h0000_0000_0000_007F, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0000_0000_0000_007F, 0});
`ifdef LSU_MISALIGNED_SPLIT_EN
    tbl.push_back('{"lw_split", 0, 2, 0, 64'h0FFE, 64'h0,            2, 0, 64'h0FF8, 8'hC0, 64'h0,                 64'h5678_0000_0000_0000, 64'h1000, 8'h03, 64'h0, 64'h0000_0000_0000_1234, 64'h0000_0000_1234_5678, 0});
    tbl.push_back('{"lh_mis", 0, 1, 0, 64'h1003, 64'h0,              1, 0, 64'h1000, 8'h18, 64'h0,                 64'h0000_0012_3400_0000, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0000_0000_0000_1234, 0});
    tbl.push_back('{"sw_split", 1, 2, 0, 64'h3006, 64'hAABB_CCDD,    2, 0, 64'h3000, 8'hC0, 64'hCCDD_0000_0000_0000, 64'h0,                 64'h3008, 8'h03, 64'hAABB, 64'h0, 64'h0,          0});
    tbl.push_back('{"sw_mis", 1, 2, 0, 64'h3001, 64'hAABB_CCDD,      1, 0, 64'h3000, 8'h1E, 64'h0000_00AA_BBCC_DD00, 64'h0,                 64'h0, 8'h00, 64'h0, 64'h0, 64'h0,                 0});
`else
    tbl.push_back('{"lw_mis", 0, 2, 0, 64'h0FFE, 64'h0,              0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0, 1});
    tbl.push_back('{"lh_mis", 0, 1, 1, 64'h1003, 64'h0,              0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0, 1});
    tbl.push_back('{"sw_mis", 1, 2, 0, 64'h3001, 64'hAABB_CCDD,      0, 0, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0, 8'h00, 64'h0, 64'h0, 64'h0, 1});
`endif

    repeat (3) @(negedge clk);
    chk("reset req_ready", 64'(bus.req_ready), 64'd1);
    chk("reset mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset mem_be", 64'(bus.mem_be), 64'd0);
    reset_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset while waiting for load data; a late rvalid must be ignored.
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 0; bus.req_size = 3; bus.req_addr = 64'h2000;
    @(posedge clk);
    #1 bus.req_valid = 0;
    @(negedge clk);
    chk("rst beat mem_valid", 64'(bus.mem_valid), 64'd1);
    bus.mem_ready = 1;
    @(negedge clk);
    bus.mem_ready = 0;
    reset_n = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rst mem_valid", 64'(bus.mem_valid), 64'd0);
      chk("rst req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    end
    reset_n = 1;
    bus.mem_rvalid = 1; bus.mem_rdata = 64'h1;
    repeat (3) begin
      @(negedge clk);
      bus.mem_rvalid = 0;
      chk("stale rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("stale req_ready", 64'(bus.req_ready), 64'd1);
    end

    // XLEN=32: doubleword is illegal, halfword load sign-extends to 32 bits.
    @(negedge clk);
    bus32.req_valid = 1; bus32.req_we = 0; bus32.req_size = 3; bus32.req_addr = 32'h10;
    @(posedge clk);
    #1 bus32.req_valid = 0;
    @(negedge clk);
    chk("x32 illegal rsp_valid", 64'(bus32.rsp_valid), 64'd1);
    chk("x32 illegal rsp_err", 64'(bus32.rsp_err), 64'd1);
    chk("x32 illegal mem_valid", 64'(bus32.mem_valid), 64'd0);
    @(negedge clk);
    bus32.req_valid = 1; bus32.req_size = 1; bus32.req_addr = 32'h16;
    @(posedge clk);
    #1 bus32.req_valid = 0;
    @(negedge clk);
    chk("x32 lh mem_valid", 64'(bus32.mem_valid), 64'd1);
    chk("x32 lh mem_addr", 64'(bus32.mem_addr), 64'h14);
    chk("x32 lh mem_be", 64'(bus32.mem_be), 64'hC);
    bus32.mem_ready = 1;
    @(negedge clk);
    bus32.mem_ready = 0; bus32.mem_rvalid = 1; bus32.mem_rdata = 32'h8001_0000;
    @(negedge clk);
    bus32.mem_rvalid = 0;
    chk("x32 lh rsp_valid", 64'(bus32.rsp_valid), 64'd1);
    chk("x32 lh rsp_rdata", 64'(bus32.rsp_rdata), 64'hFFFF_8001);
    chk("x32 lh rsp_err", 64'(bus32.rsp_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
